ula_mul_seq: RTL and testbench

//  Multi-cycle sequencer for MULT/MULTU. Drives the shared 32-bit ula through
//  a fixed shift-add schedule and leaves the 64-bit product in hi/lo.

---
 rtl/ula_mul_seq.sv | 164 ++++++++++++++++
 tb/tb_ula_mul_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ula_mul_seq                                                |
// | Purpose : Multi-cycle MULT/MULTU sequencer. Borrows the shared 32-bit |
// |           ula for a fixed shift-add schedule and leaves the 64-bit   |
// |           product in hi/lo. Signed operands are reduced to their     |
// |           magnitudes, multiplied unsigned, then the product is       |
// |           conditionally negated, so latency never depends on data.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ula_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [2:0] c_idle       = 3'd0;
  localparam logic [2:0] c_abs_a      = 3'd1;
  localparam logic [2:0] c_abs_b      = 3'd2;
  localparam logic [2:0] c_mul        = 3'd3;
  localparam logic [2:0] c_neg_lo     = 3'd4;
  localparam logic [2:0] c_neg_hi_inv = 3'd5;
  localparam logic [2:0] c_neg_hi_inc = 3'd6;
  localparam logic [2:0] c_done       = 3'd7;

  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_nor = 4'b0100;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [4:0]       r_cnt;
  logic             r_neg;
  logic             r_lo_zero;
  logic             r_sgn;
  logic             w_carry;

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = (r_state != c_idle) && (r_state != c_done);
  assign done      = (r_state == c_done);
  assign alu_shamt = 5'd0;

  // The ula has no carry-out, so recover it from the unsigned wrap of hi+addend.
  assign w_carry = (alu_result < r_hi);

  // Select ula operands and operation from the current state.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = c_op_add;
    case (r_state)
      c_abs_a: begin
        alu_control = c_op_sub;
        alu_b       = r_mcand;
      end
      c_abs_b: begin
        alu_control = c_op_sub;
        alu_b       = r_lo;
      end
      c_mul: begin
        alu_control = c_op_add;
        alu_a       = r_hi;
        alu_b       = r_lo[0] ? r_mcand : '0;
      end
      c_neg_lo: begin
        alu_control = c_op_sub;
        alu_b       = r_lo;
      end
      c_neg_hi_inv: begin
        alu_control = c_op_nor;
        alu_a       = r_hi;
      end
      c_neg_hi_inc: begin
        alu_control = c_op_add;
        alu_a       = r_hi;
        alu_b       = {{(WIDTH-1){1'b0}}, r_lo_zero};
      end
      default: begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = c_op_add;
      end
    endcase
  end

  // Sequencer: state advance plus the register update each state performs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_idle;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_lo_zero <= 1'b0;
      r_sgn     <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_mcand <= op_a;
            r_lo    <= op_b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_sgn   <= is_signed;
            r_neg   <= (op_a[WIDTH-1] ^ op_b[WIDTH-1]) & is_signed;
            r_state <= is_signed ? c_abs_a : c_mul;
          end
        end
        c_abs_a: begin
          if (r_mcand[WIDTH-1]) r_mcand <= alu_result;
          r_state <= c_abs_b;
        end
        c_abs_b: begin
          if (r_lo[WIDTH-1]) r_lo <= alu_result;
          r_state <= c_mul;
        end
        c_mul: begin
          // Shift the 65-bit {carry, sum, lo} pair right by one each step.
          r_hi  <= {w_carry, alu_result[WIDTH-1:1]};
          r_lo  <= {alu_result[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= r_sgn ? c_neg_lo : c_done;
        end
        c_neg_lo: begin
          // A zero low word means the two's-complement increment carries into hi.
          r_lo_zero <= (r_lo == '0);
          if (r_neg) r_lo <= alu_result;
          r_state <= c_neg_hi_inv;
        end
        c_neg_hi_inv: begin
          if (r_neg) r_hi <= alu_result;
          r_state <= c_neg_hi_inc;
        end
        c_neg_hi_inc: begin
          if (r_neg) r_hi <= alu_result;
          r_state <= c_done;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ula_mul_seq                                             |
// | Purpose : Scoreboard bench for ula_mul_seq with a behavioural ula.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ula_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    bit          sgn;
  } exp_t;

  exp_t      exp_q[$];
  logic [3:0] trace[$];
  int        tests = 0;
  int        fails = 0;
  int        cyc   = 0;

  ula_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_control(alu_control), .alu_result(alu_result)
  );

  // Behavioural combinational ula.
  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: checks every done against the oldest expected result.
  initial begin
    exp_t e;
    bit   tr_ok;
    forever begin
      @(negedge clk);
      if (reset) begin
        trace.delete();
      end else begin
        chk("shamt", {59'd0, alu_shamt}, 64'd0);
        if (busy) trace.push_back(alu_control);
        if (done) begin
          chk("busy_in_done", {63'd0, busy}, 64'd0);
          if (exp_q.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("hi", {32'd0, hi}, {32'd0, e.hi});
            chk("lo", {32'd0, lo}, {32'd0, e.lo});
            chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            // Expected ula op sequence while busy.
            tr_ok = (trace.size() == (e.sgn ? 37 : 32));
            for (int i = 0; i < trace.size() && tr_ok; i++) begin
              if (e.sgn) begin
                if (i < 2 || i == 34) tr_ok = (trace[i] == 4'b0110);
                else if (i == 35)     tr_ok = (trace[i] == 4'b0100);
                else                  tr_ok = (trace[i] == 4'b0010);
              end else begin
                tr_ok = (trace[i] == 4'b0010);
              end
            end
            chk("alu_control_trace", {63'd0, tr_ok}, 64'd1);
          end
          trace.delete();
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      $display("FAIL wait_idle: busy=%0b done=%0b after %0d cycles", busy, done, n);
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
    end
  endtask

  // Issue one multiply at a negedge; expected product from plain arithmetic.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s);
    exp_t   e;
    longint pa, pb;
    logic [63:0] p;
    wait_idle();
    pa = s ? longint'($signed(a)) : longint'({32'd0, a});
    pb = s ? longint'($signed(b)) : longint'({32'd0, b});
    p  = 64'(pa * pb);
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.sgn = s;
    e.cyc = cyc + 1 + (s ? 37 : 32);
    exp_q.push_back(e);
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1; op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFD};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_ctrl", {60'd0, alu_control}, 64'd2);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);

    // Directed cases, including boundaries.
    launch(32'd7, 32'd6, 1'b0);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    launch(32'hFFFFFFFD, 32'd5, 1'b1);
    launch(32'h80000000, 32'h80000000, 1'b1);
    launch(32'hFFFFFFFF, 32'd0, 1'b1);
    launch(32'd0, 32'h80000000, 1'b1);
    launch(32'h80000000, 32'd1, 1'b1);
    launch(32'h7FFFFFFF, 32'h80000000, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 40; i++) launch(pick(), pick(), 1'($urandom));

    // Start pulses while busy must be ignored.
    launch(32'h12345678, 32'h9ABCDEF0, 1'b0);
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (9) @(negedge clk);
    pulse_start();
    repeat (12) @(negedge clk);
    pulse_start();
    launch(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();

    // Reset in the middle of MUL (cnt=10).
    launch(32'hFFFF0000, 32'h0000FFFF, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    launch(32'hFFFFFFF9, 32'd9, 1'b1);
    launch(32'd100, 32'd200, 1'b0);

    // Drain outstanding results.
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
